// File: rtl/qerv_bufreg2_gen.sv
`default_nettype none
// ============================================================================
//  Module   : qerv_bufreg2_gen
//  Brief    : W-bit-per-cycle data/shift buffer register with shift-amount FSM
//  Revision : 1.0
// ============================================================================
module qerv_bufreg2_gen #(
   parameter int BITS_PER_CYCLE = 4,
   parameter int LB = (BITS_PER_CYCLE > 1) ? $clog2(BITS_PER_CYCLE) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_en,
   input  logic                      i_init,
   input  logic                      i_cnt_done,
   input  logic [1:0]                i_lsb,
   input  logic                      i_byte_valid,
   input  logic                      i_op_b_sel,
   input  logic                      i_shift_op,
   input  logic                      i_right_shift_op,
   input  logic [BITS_PER_CYCLE-1:0] i_rs2,
   input  logic [BITS_PER_CYCLE-1:0] i_imm,
   input  logic                      i_load,
   input  logic [31:0]               i_dat,
   output logic [BITS_PER_CYCLE-1:0] o_op_b,
   output logic [BITS_PER_CYCLE-1:0] o_q,
   output logic [31:0]               o_dat,
   output logic                      o_sh_done,
   output logic                      o_sh_done_r,
   output logic [LB-1:0]             o_shift_counter_lsb,
   output logic                      o_busy
);

   localparam int W = BITS_PER_CYCLE;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ALIGN = 2'd1;
   localparam logic [1:0] c_COUNT = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   localparam logic [5:0] c_STEP = 6'(W);

   logic [31:0] dat_q, dat_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [1:0]  state_q, state_d;
   logic [5:0]  cnt_dec;
   logic        count_en;
   logic        start;
   logic        rem_nz;
   logic        align_req;

   assign o_op_b   = i_op_b_sel ? i_rs2 : i_imm;
   assign o_q      = dat_q[{i_lsb, 3'b000} +: W];
   assign o_dat    = dat_q;
   assign cnt_dec  = cnt_q - c_STEP;
   assign count_en = i_shift_op & ~i_init;
   assign start    = i_en & i_init & i_cnt_done & i_shift_op;

   // Done fires on the decrement that wraps the counter below zero.
   assign o_sh_done   = (state_q == c_COUNT) & count_en & cnt_dec[5];
   assign o_sh_done_r = (state_q == c_DONE) & cnt_q[5];
   assign o_busy      = (state_q != c_IDLE);
   assign align_req   = i_right_shift_op & rem_nz;

   generate
      if (W > 1) begin : g_align
         assign rem_nz              = (dat_q[W+LB-1:W] != '0);
         assign o_shift_counter_lsb = (state_q == c_ALIGN) ? cnt_q[LB-1:0] : '0;
      end else begin : g_no_align
         assign rem_nz              = 1'b0;
         assign o_shift_counter_lsb = '0;
      end
   endgenerate

   always_comb begin
      dat_d = dat_q;
      if (i_load)
         dat_d = i_dat;
      else if (i_shift_op | (i_en & i_byte_valid))
         dat_d = {o_op_b, dat_q[31:W]};
   end

   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      case (state_q)
         c_IDLE: begin
            // Shamt sits W bits up because dat shifts on this same cycle.
            if (start) begin
               cnt_d   = {1'b0, dat_q[W+4:W]};
               state_d = align_req ? c_ALIGN : c_COUNT;
            end
         end
         c_ALIGN: state_d = i_shift_op ? c_COUNT : c_IDLE;
         c_COUNT: begin
            if (!i_shift_op)
               state_d = c_IDLE;
            else if (!i_init) begin
               cnt_d = cnt_dec;
               if (cnt_dec[5])
                  state_d = c_DONE;
            end
         end
         c_DONE: if (!i_shift_op) state_d = c_IDLE;
         default: state_d = c_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         dat_q   <= '0;
         cnt_q   <= '0;
         state_q <= c_IDLE;
      end else begin
         dat_q   <= dat_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qerv_bufreg2_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qerv_bufreg2_gen
//  Brief    : Self-checking bench for qerv_bufreg2_gen at W=1, 4 and 8
//  Revision : 1.0
// ============================================================================
module tb_qerv_bufreg2_gen;

   logic        clk, rst, en, init, cnt_done, byte_valid, op_b_sel;
   logic        shift_op, right, load;
   logic [1:0]  lsb;
   logic [7:0]  rs2_8, imm_8;
   logic [31:0] idat;

   logic [0:0]  op_b1, q1;
   logic [3:0]  op_b4, q4;
   logic [7:0]  op_b8, q8;
   logic [31:0] o_dat1, o_dat4, o_dat8;
   logic        done1, done4, done8, done_r1, done_r4, done_r8;
   logic        busy1, busy4, busy8;
   logic [0:0]  lsbo1;
   logic [1:0]  lsbo4;
   logic [2:0]  lsbo8;

   int          checks = 0;
   int          failures = 0;
   bit          rnd;
   logic [31:0] m_dat [3];
   int          wv [3] = '{1, 4, 8};

   qerv_bufreg2_gen #(.BITS_PER_CYCLE(1)) u_w1 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
      .i_lsb(lsb), .i_byte_valid(byte_valid), .i_op_b_sel(op_b_sel),
      .i_shift_op(shift_op), .i_right_shift_op(right), .i_rs2(rs2_8[0:0]),
      .i_imm(imm_8[0:0]), .i_load(load), .i_dat(idat), .o_op_b(op_b1), .o_q(q1),
      .o_dat(o_dat1), .o_sh_done(done1), .o_sh_done_r(done_r1),
      .o_shift_counter_lsb(lsbo1), .o_busy(busy1));

   qerv_bufreg2_gen #(.BITS_PER_CYCLE(4)) u_w4 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
      .i_lsb(lsb), .i_byte_valid(byte_valid), .i_op_b_sel(op_b_sel),
      .i_shift_op(shift_op), .i_right_shift_op(right), .i_rs2(rs2_8[3:0]),
      .i_imm(imm_8[3:0]), .i_load(load), .i_dat(idat), .o_op_b(op_b4), .o_q(q4),
      .o_dat(o_dat4), .o_sh_done(done4), .o_sh_done_r(done_r4),
      .o_shift_counter_lsb(lsbo4), .o_busy(busy4));

   qerv_bufreg2_gen #(.BITS_PER_CYCLE(8)) u_w8 (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_init(init), .i_cnt_done(cnt_done),
      .i_lsb(lsb), .i_byte_valid(byte_valid), .i_op_b_sel(op_b_sel),
      .i_shift_op(shift_op), .i_right_shift_op(right), .i_rs2(rs2_8),
      .i_imm(imm_8), .i_load(load), .i_dat(idat), .o_op_b(op_b8), .o_q(q8),
      .o_dat(o_dat8), .o_sh_done(done8), .o_sh_done_r(done_r8),
      .o_shift_counter_lsb(lsbo8), .o_busy(busy8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] dut_dat(input int k);
      case (k) 0: return o_dat1; 1: return o_dat4; default: return o_dat8; endcase
   endfunction
   function automatic logic [31:0] dut_done(input int k);
      case (k) 0: return 32'(done1); 1: return 32'(done4); default: return 32'(done8); endcase
   endfunction
   function automatic logic [31:0] dut_done_r(input int k);
      case (k) 0: return 32'(done_r1); 1: return 32'(done_r4); default: return 32'(done_r8); endcase
   endfunction
   function automatic logic [31:0] dut_busy(input int k);
      case (k) 0: return 32'(busy1); 1: return 32'(busy4); default: return 32'(busy8); endcase
   endfunction
   function automatic logic [31:0] dut_lsbo(input int k);
      case (k) 0: return 32'(lsbo1); 1: return 32'(lsbo4); default: return 32'(lsbo8); endcase
   endfunction

   // Reference: the register is a 32-bit word fed W new bits at the top each shift.
   function automatic logic [31:0] shifted(input logic [31:0] d, input int w, input logic [7:0] opb);
      logic [31:0] ins;
      ins = 32'(opb) & ((32'd1 << w) - 32'd1);
      return (d >> w) | (ins << (32 - w));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      logic [31:0] nxt [3];
      logic [7:0]  opb;
      logic [31:0] word4;
      #1;
      opb = op_b_sel ? rs2_8 : imm_8;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("dat_w%0d", wv[k]), dut_dat(k), m_dat[k]);
         if (load) nxt[k] = idat;
         else if (shift_op | (en & byte_valid)) nxt[k] = shifted(m_dat[k], wv[k], opb);
         else nxt[k] = m_dat[k];
      end
      word4 = m_dat[1] >> (8 * int'(lsb));
      chk("q_w4", 32'(q4), word4 & 32'hF);
      chk("op_b_w4", 32'(op_b4), 32'(opb & 8'h0F));
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) m_dat[k] = nxt[k];
      if (rnd) begin
         rs2_8      = 8'($urandom);
         imm_8      = 8'($urandom);
         lsb        = 2'($urandom_range(0, 3));
         op_b_sel   = 1'($urandom_range(0, 1));
         byte_valid = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic do_shift(input int k, input int shamt, input bit rt, input int load_at, input int abort_at);
      bit exp_align;
      int ncnt;
      exp_align = rt && (wv[k] > 1) && ((shamt % wv[k]) != 0);
      ncnt      = shamt / wv[k] + 1;
      en = 0; init = 0; cnt_done = 0; shift_op = 0; load = 1;
      idat = 32'(shamt) << wv[k];
      cyc();
      load = 0;
      chk("idle_busy", dut_busy(k), 0);
      en = 1; init = 1; cnt_done = 1; shift_op = 1; right = rt;
      #1 chk("trigger_done", dut_done(k), 0);
      cyc();
      init = 0; cnt_done = 0;
      if (exp_align) begin
         #1;
         chk("align_busy", dut_busy(k), 1);
         chk("align_lsb", dut_lsbo(k), 32'(shamt % wv[k]));
         chk("align_done", dut_done(k), 0);
         cyc();
      end
      for (int n = 1; n <= ncnt; n++) begin
         if (n == abort_at) begin
            shift_op = 0;
            #1 chk("abort_done", dut_done(k), 0);
            cyc();
            chk("abort_busy", dut_busy(k), 0);
            return;
         end
         if (n == load_at) begin
            load = 1; en = 1; byte_valid = 1; idat = 32'hDEADBEEF;
         end
         #1;
         chk($sformatf("done_w%0d_s%0d_c%0d", wv[k], shamt, n), dut_done(k), 32'(n == ncnt));
         chk("count_lsb", dut_lsbo(k), 0);
         chk("count_done_r", dut_done_r(k), 0);
         cyc();
         if (n == load_at) begin
            load = 0;
            chk("load_dat", dut_dat(k), 32'hDEADBEEF);
         end
      end
      chk("done_r", dut_done_r(k), 1);
      chk("done_busy", dut_busy(k), 1);
      chk("done_no_pulse", dut_done(k), 0);
      cyc();
      chk("done_r_hold", dut_done_r(k), 1);
      shift_op = 0;
      cyc();
      chk("end_busy", dut_busy(k), 0);
      chk("end_done_r", dut_done_r(k), 0);
   endtask

   initial begin
      logic [31:0] word;
      rst = 1; en = 0; init = 0; cnt_done = 0; byte_valid = 0; op_b_sel = 0;
      shift_op = 0; right = 0; load = 0; lsb = 0; rs2_8 = 0; imm_8 = 0; idat = 0;
      rnd = 0;
      for (int k = 0; k < 3; k++) m_dat[k] = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_dat", dut_dat(k), 0);
         chk("rst_busy", dut_busy(k), 0);
         chk("rst_done", dut_done(k), 0);
         chk("rst_done_r", dut_done_r(k), 0);
         chk("rst_lsb", dut_lsbo(k), 0);
      end
      rst = 0;

      // Serial load of an rs2 word through the W=4 slice
      word = $urandom;
      en = 1; byte_valid = 1; op_b_sel = 1;
      for (int i = 0; i < 8; i++) begin
         rs2_8 = {4'h0, word[4*i +: 4]};
         cyc();
      end
      en = 0;
      chk("t1_dat", 32'(o_dat4), word);
      lsb = 2;
      #1 chk("t1_q_lsb2", 32'(q4), 32'(word[19:16]));

      rnd = 1;
      do_shift(1, 13, 1, 0, 0);
      do_shift(1, 12, 0, 0, 0);
      do_shift(0, 0, 1, 0, 0);
      do_shift(0, 31, 1, 0, 0);
      do_shift(1, 20, 1, 2, 0);
      do_shift(2, 30, 1, 0, 0);
      do_shift(1, 28, 1, 0, 3);

      for (int r = 0; r < 16; r++) begin
         int k, s, ab;
         k  = $urandom_range(0, 2);
         s  = $urandom_range(0, 31);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, s / wv[k] + 1) : 0;
         if (ab == s / wv[k] + 1) ab = 0;
         do_shift(k, s, 1'($urandom_range(0, 1)), 0, ab);
      end

      // Asynchronous reset in the middle of a W=8 count
      en = 0; init = 0; cnt_done = 0; shift_op = 0; load = 1; idat = 32'(30) << 8;
      cyc();
      load = 0; en = 1; init = 1; cnt_done = 1; shift_op = 1; right = 1;
      cyc();
      init = 0; cnt_done = 0;
      cyc();
      cyc();
      chk("t6_busy_pre", 32'(busy8), 1);
      #2 rst = 1;
      #1;
      chk("t6_busy", 32'(busy8), 0);
      chk("t6_done_r", 32'(done_r8), 0);
      chk("t6_dat", o_dat8, 0);
      chk("t6_done", 32'(done8), 0);
      for (int k = 0; k < 3; k++) m_dat[k] = '0;
      en = 0; shift_op = 0; right = 0;
      @(posedge clk);
      #1 rst = 0;
      cyc();
      chk("t6_busy_post", 32'(busy8), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
